// File: rtl/retire_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_pkg
// Purpose  : Shared record layout for the retire trace buffer. Matches the
//            70-bit inst_retire bus used by the golden-trace comparison.
// Revision : 1.0 - initial release
// ============================================================================
package retire_trace_pkg;

  localparam int REC_W     = 70;
  localparam int PC_LSB    = 0;
  localparam int WDATA_LSB = 32;
  localparam int WADDR_LSB = 64;
  localparam int RFEN_BIT  = 69;

  // Field order gives rf_en at bit 69 down to pc at bits 31:0
  typedef struct packed {
    logic        rf_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } retire_rec_t;

  function automatic retire_rec_t pack_rec(input logic        rf_en,
                                           input logic [4:0]  waddr,
                                           input logic [31:0] wdata,
                                           input logic [31:0] pc);
    retire_rec_t r;
    r.rf_en = rf_en;
    r.waddr = waddr;
    r.wdata = wdata;
    r.pc    = pc;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_fifo
// Purpose  : Synchronous show-ahead FIFO. The head entry is presented
//            combinationally from storage; a push never bypasses to the head
//            in the same cycle. Pop and push on a full FIFO are both taken.
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = REC_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Guard pop against empty and push against full-without-pop, then advance
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers; reset discards all entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head is zeroed when empty so the output bus is quiet
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    count     = count_q;
    head_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: rtl/retire_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_buf
// Purpose  : Captures retired-instruction records from writeback, filters
//            them, and buffers them for a trace consumer. When full it either
//            stalls writeback or drops the record and counts the drop.
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_buf
  import retire_trace_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int FILTER_RF     = 1,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic                     wb_rf_wen,
  input  logic [4:0]               wb_rf_waddr,
  input  logic [31:0]              wb_rf_wdata,
  output logic                     wb_stall,
  output logic [REC_W-1:0]         inst_retire,
  output logic                     retire_valid,
  input  logic                     retire_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              ovf_cnt,
  output logic                     ovf
);

  logic        qual;
  logic        deq;
  logic        enq;
  logic        blocked;
  logic        drop;
  logic        full;
  logic        empty;
  retire_rec_t rec;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_q, ovf_d;

  // Select which retires are worth tracing
  if (FILTER_RF != 0) begin : g_filter_rf
    assign qual = wb_valid & wb_rf_wen & (wb_rf_waddr != 5'd0);
  end else begin : g_filter_none
    assign qual = wb_valid;
  end

  // A full buffer only blocks the retire if nothing leaves this cycle
  always_comb begin
    deq     = retire_valid & retire_ready;
    blocked = qual & full & ~deq;
    enq     = qual & ~blocked;
    rec     = pack_rec(wb_rf_wen, wb_rf_waddr, wb_rf_wdata, wb_pc);
  end

  // Blocked retires either hold writeback or are discarded
  if (STALL_ON_FULL != 0) begin : g_stall
    assign wb_stall = blocked;
    assign drop     = 1'b0;
  end else begin : g_drop
    assign wb_stall = 1'b0;
    assign drop     = blocked;
  end

  retire_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (rec),
    .pop       (deq),
    .head_data (inst_retire),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Drop counter saturates; the sticky flag records that any drop occurred
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    ovf_d     = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end
  end

  // Overflow state clears only on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Drive status outputs from state
  always_comb begin
    retire_valid = ~empty;
    ovf_cnt      = ovf_cnt_q;
    ovf          = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_trace_buf
// Purpose  : Directed self-checking bench. Instance a uses the default
//            configuration (filter on, stall on full); instance b has the
//            filter off and drops on full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buf;

  logic clk;
  logic rst;

  logic        a_valid, a_wen, a_stall, a_rvalid, a_ready, a_ovf;
  logic [31:0] a_pc, a_wdata;
  logic [4:0]  a_waddr;
  logic [69:0] a_rec;
  logic [4:0]  a_count;
  logic [15:0] a_ovf_cnt;

  logic        b_valid, b_wen, b_stall, b_rvalid, b_ready, b_ovf;
  logic [31:0] b_pc, b_wdata;
  logic [4:0]  b_waddr;
  logic [69:0] b_rec;
  logic [4:0]  b_count;
  logic [15:0] b_ovf_cnt;

  int errors;
  int checks;

  retire_trace_buf #(.DEPTH(16), .FILTER_RF(1), .STALL_ON_FULL(1)) dut_a (
    .clk(clk), .rst(rst),
    .wb_valid(a_valid), .wb_pc(a_pc), .wb_rf_wen(a_wen),
    .wb_rf_waddr(a_waddr), .wb_rf_wdata(a_wdata), .wb_stall(a_stall),
    .inst_retire(a_rec), .retire_valid(a_rvalid), .retire_ready(a_ready),
    .count(a_count), .ovf_cnt(a_ovf_cnt), .ovf(a_ovf)
  );

  retire_trace_buf #(.DEPTH(16), .FILTER_RF(0), .STALL_ON_FULL(0)) dut_b (
    .clk(clk), .rst(rst),
    .wb_valid(b_valid), .wb_pc(b_pc), .wb_rf_wen(b_wen),
    .wb_rf_waddr(b_waddr), .wb_rf_wdata(b_wdata), .wb_stall(b_stall),
    .inst_retire(b_rec), .retire_valid(b_rvalid), .retire_ready(b_ready),
    .count(b_count), .ovf_cnt(b_ovf_cnt), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] mk_rec(input logic wen, input logic [4:0] wa,
                                         input logic [31:0] wd, input logic [31:0] pc);
    return {wen, wa, wd, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd);
    a_valid = v; a_pc = pc; a_wen = wen; a_waddr = wa; a_wdata = wd;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd);
    b_valid = v; b_pc = pc; b_wen = wen; b_waddr = wa; b_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", a_rvalid); end
    checks++; if (a_rec !== 70'd0) begin errors++; $display("FAIL reset_rec got=%h exp=0", a_rec); end
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (b_ovf_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf_cnt got=%0d exp=0", b_ovf_cnt); end
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", b_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [69:0] exp_rec;
    exp_rec = 70'h25_DEAD_BEEF_0000_0100;
    drive_a(1'b1, 32'h0000_0100, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", a_rvalid); end
    checks++; if (a_rec !== exp_rec) begin errors++; $display("FAIL single_rec got=%h exp=%h", a_rec, exp_rec); end
    checks++; if (a_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", a_count); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", a_count); end
  endtask

  task automatic test_filter();
    logic [69:0] exp_b;
    exp_b = mk_rec(1'b1, 5'd0, 32'h1111_1111, 32'h200);
    drive_a(1'b1, 32'h200, 1'b1, 5'd0, 32'h1111_1111);
    drive_b(1'b1, 32'h200, 1'b1, 5'd0, 32'h1111_1111);
    tick();
    drive_a(1'b1, 32'h204, 1'b0, 5'd3, 32'h2222_2222);
    drive_b(1'b1, 32'h204, 1'b0, 5'd3, 32'h2222_2222);
    tick();
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL filter_count got=%0d exp=0", a_count); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL filter_valid got=%b exp=0", a_rvalid); end
    checks++; if (b_count !== 5'd2) begin errors++; $display("FAIL nofilter_count got=%0d exp=2", b_count); end
    checks++; if (b_rec !== exp_b) begin errors++; $display("FAIL nofilter_rec got=%h exp=%h", b_rec, exp_b); end
    b_ready = 1'b1;
    tick();
    tick();
    b_ready = 1'b0;
    checks++; if (b_count !== 5'd0) begin errors++; $display("FAIL nofilter_drain got=%0d exp=0", b_count); end
  endtask

  task automatic test_stall_full();
    int stall_early;
    logic [69:0] exp_rec;
    stall_early = 0;
    a_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive_a(1'b1, 32'(i), 1'b1, 5'(i), 32'hA000_0000 | 32'(i));
      #1;
      if (a_stall !== 1'b0) stall_early++;
      tick();
    end
    checks++; if (stall_early != 0) begin errors++; $display("FAIL stall_early got=%0d exp=0", stall_early); end
    checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL stall_fill_count got=%0d exp=16", a_count); end
    drive_a(1'b1, 32'd17, 1'b1, 5'd17, 32'hA000_0011);
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL stall_17th got=%b exp=1", a_stall); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=%b exp=1", c, a_stall); end
      checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL stall_hold_count%0d got=%0d exp=16", c, a_count); end
    end
    a_ready = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", a_stall); end
    tick();
    a_ready = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL stall_swap_count got=%0d exp=16", a_count); end
    checks++; if (a_rec[31:0] !== 32'd2) begin errors++; $display("FAIL stall_head_pc got=%0d exp=2", a_rec[31:0]); end
    for (int k = 2; k <= 17; k++) begin
      exp_rec = mk_rec(1'b1, 5'(k), 32'hA000_0000 | 32'(k), 32'(k));
      checks++; if (a_rec !== exp_rec) begin errors++; $display("FAIL stall_drain%0d got=%h exp=%h", k, a_rec, exp_rec); end
      a_ready = 1'b1;
      tick();
    end
    a_ready = 1'b0;
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL stall_empty got=%0d exp=0", a_count); end
  endtask

  task automatic test_drop();
    int stall_seen;
    stall_seen = 0;
    b_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive_b(1'b1, 32'(i), 1'b0, 5'd0, 32'h5000_0000 | 32'(i));
      #1;
      if (b_stall !== 1'b0) stall_seen++;
      tick();
    end
    drive_b(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (stall_seen != 0) begin errors++; $display("FAIL drop_stall got=%0d exp=0", stall_seen); end
    checks++; if (b_ovf_cnt !== 16'd4) begin errors++; $display("FAIL drop_ovf_cnt got=%0d exp=4", b_ovf_cnt); end
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%b exp=1", b_ovf); end
    checks++; if (b_count !== 5'd16) begin errors++; $display("FAIL drop_count got=%0d exp=16", b_count); end
    for (int k = 1; k <= 16; k++) begin
      checks++; if (b_rec[31:0] !== 32'(k)) begin errors++; $display("FAIL drop_order%0d got=%0d exp=%0d", k, b_rec[31:0], k); end
      b_ready = 1'b1;
      tick();
    end
    b_ready = 1'b0;
    checks++; if (b_count !== 5'd0) begin errors++; $display("FAIL drop_empty got=%0d exp=0", b_count); end
    checks++; if (b_ovf_cnt !== 16'd4) begin errors++; $display("FAIL drop_ovf_keep got=%0d exp=4", b_ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 32'h1000, 1'b1, 5'd7, 32'h7777_0000);
    tick();
    for (int i = 0; i < 100; i++) begin
      checks++; if (a_rec[31:0] !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL b2b_head%0d got=%h exp=%h", i, a_rec[31:0], 32'h1000 + 32'(i)); end
      drive_a(1'b1, 32'h1000 + 32'(i) + 32'd1, 1'b1, 5'd7, 32'h7777_0000 | 32'(i + 1));
      a_ready = 1'b1;
      #1;
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got=%b exp=0", i, a_stall); end
      tick();
      checks++; if (a_count !== 5'd1) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=1", i, a_count); end
    end
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (a_rec !== mk_rec(1'b1, 5'd7, 32'h7777_0064, 32'h1064)) begin errors++; $display("FAIL b2b_last got=%h", a_rec); end
    tick();
    a_ready = 1'b0;
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", a_count); end
  endtask

  task automatic test_mid_reset();
    a_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_a(1'b1, 32'h3000 + 32'(i), 1'b1, 5'd9, 32'h0);
      tick();
    end
    checks++; if (a_count !== 5'd9) begin errors++; $display("FAIL mrst_pre_count got=%0d exp=9", a_count); end
    // b still carries ovf_cnt=4 from the drop scenario
    rst = 1'b1;
    drive_a(1'b1, 32'h0999, 1'b1, 5'd9, 32'h9);
    drive_b(1'b1, 32'h0999, 1'b1, 5'd9, 32'h9);
    tick();
    rst = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", a_count); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", a_rvalid); end
    checks++; if (a_rec !== 70'd0) begin errors++; $display("FAIL mrst_rec got=%h exp=0", a_rec); end
    checks++; if (b_ovf_cnt !== 16'd0) begin errors++; $display("FAIL mrst_ovf_cnt got=%0d exp=0", b_ovf_cnt); end
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL mrst_ovf got=%b exp=0", b_ovf); end
    checks++; if (b_count !== 5'd0) begin errors++; $display("FAIL mrst_b_count got=%0d exp=0", b_count); end
    tick();
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL mrst_not_captured got=%0d exp=0", a_count); end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_single();
    test_filter();
    test_stall_full();
    test_drop();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
